pulse_fifo_read_scheduler: RTL
==============================

# pulse_fifo_read_scheduler

Sequences all reads of the photon pulse-count FIFO and shares each popped word between the two consumers, the TFT 4.3" display adapter and the UART reporter. On every qualified 50 Hz sync tick it pops exactly one word and offers it to both consumers over independent valid/ready handshakes. It holds the word stable until both accept or a timeout expires, and it counts missed ticks and timeouts for diagnostics. It sits between the pulse-count FIFO read port and the display/UART blocks, all in the 80 MHz PLL domain.

## Interface
Parameters:
- DATA_W, 32, FIFO word width and output data width.
- TIMEOUT_CYC, 1600000, cycles allowed in OFFER before forced abandon (20 ms at 80 MHz); must be ≥ 2.

Ports:
- clk  in  1  80 MHz system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  scheduler enable; gates acceptance of new ticks only.
- sync_tick  in  1  single-cycle pulse on the 50 Hz sync rising edge.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; one cycle per transaction.
- fifo_dout  in  DATA_W  FIFO read data, valid one cycle after fifo_rd_en.
- word_out  out  DATA_W  captured word shared by both consumers.
- tft_valid  out  1  word offered to the display adapter.
- tft_ready  in  1  display adapter accepts.
- uart_valid  out  1  word offered to the UART reporter.
- uart_ready  in  1  UART reporter accepts.
- busy  out  1  high in every state except IDLE.
- missed_ticks  out  16  saturating count of dropped ticks.
- timeouts  out  8  saturating count of abandoned offers.

## Operation
- Reset value of every output is 0, including word_out, the counters and the FSM state (IDLE). All outputs are registered.
- FSM states: IDLE, READ, CAPTURE, OFFER.
- IDLE: the tick is accepted when sync_tick=1, en=1 and fifo_empty=0.
  - On acceptance: next state is READ.
  - sync_tick=1, en=1, fifo_empty=1: missed_ticks increments and the state stays IDLE.
  - en=0: ticks are ignored and not counted.
- READ: fifo_rd_en=1 for exactly this cycle. Next state is CAPTURE.
- CAPTURE: word_out <= fifo_dout. Both valids are set at the same edge. The timeout counter clears. Next state is OFFER.
- OFFER: each valid holds until its own handshake, which is valid & ready at a clock edge. After its handshake, that valid falls at the next edge.
  - Exit 1: when both handshakes are complete, the state returns to IDLE. Both may complete in the same cycle, or in different cycles.
  - Exit 2: if the timeout counter reaches TIMEOUT_CYC-1 before both handshakes complete, both valids are forced low and timeouts increments. The state returns to IDLE.
  - A handshake in the timeout cycle counts as completed. If that handshake finishes the transaction, timeouts does not increment.
- word_out is stable from CAPTURE until the next CAPTURE. It is never changed while either valid is high.
- Any sync_tick seen while the state is not IDLE increments missed_ticks. Such a tick is never queued.
- If en falls mid-transaction, the transaction still completes normally.
- Both counters saturate at all-ones and never wrap.
- Reset asserted mid-transaction: all state clears immediately and asynchronously. A FIFO word that was already popped is lost. No read is issued after reset releases until a new tick arrives.

## Timing
- Accepted tick in cycle T:
  - fifo_rd_en high in cycle T+1.
  - fifo_dout sampled in cycle T+2.
  - word_out, tft_valid and uart_valid high from cycle T+3.
- Both ready in cycle T+3: valids and busy fall in T+4, and the state is IDLE in T+4. A tick in T+4 is accepted.
- A tick arriving in the same cycle as the final handshake is counted as missed.
- Minimum transaction length is 4 cycles, well under the 1.6M-cycle tick period.
- At most one fifo_rd_en per accepted tick. fifo_rd_en is never asserted while fifo_empty=1 was sampled in the deciding cycle.

## Test plan
- Single tick, FIFO holds 0x12345678, both ready held high:
  - fifo_rd_en pulses at T+1; word_out=0x12345678 and both valids high at T+3; both valids low at T+4.
  - missed_ticks=0, timeouts=0.
- Staggered accept, tft_ready high at T+3, uart_ready held low until T+10:
  - tft_valid low from T+4; uart_valid high through T+10 and low at T+11; busy low at T+11; word_out unchanged throughout.
- Tick with fifo_empty=1: no fifo_rd_en; missed_ticks=1; busy stays 0.
- Ticks during a transaction: uart_ready held low, 3 extra ticks while in OFFER, TIMEOUT_CYC=16:
  - missed_ticks=3; both valids drop after 16 OFFER cycles; timeouts=1; the next tick is accepted normally.
- Reset mid-transaction: rst_n driven low during OFFER:
  - all outputs 0 immediately; after release, no read occurs without a new tick.
- Saturation: 65540 ticks with FIFO empty: missed_ticks=0xFFFF. Then en=0 with further ticks: count unchanged, no reads.

Source files
------------

// File: rtl/pulse_fifo_read_scheduler_if.sv
// Handshake bundle between the pulse-count FIFO read scheduler and its neighbours:
// FIFO read port on one side, the shared word offered to the TFT and UART consumers on the other.
interface pulse_fifo_read_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] word_out;
    logic              tft_valid;
    logic              tft_ready;
    logic              uart_valid;
    logic              uart_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  tft_ready,
        input  uart_ready,
        output fifo_rd_en,
        output word_out,
        output tft_valid,
        output uart_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output tft_ready,
        output uart_ready,
        input  fifo_rd_en,
        input  word_out,
        input  tft_valid,
        input  uart_valid
    );
endinterface

// File: rtl/pulse_fifo_read_scheduler.sv
// Pops one pulse-count word per qualified 50 Hz tick and offers it to the TFT and UART
// consumers until both accept or the offer times out; keeps missed-tick/timeout diagnostics.
module pulse_fifo_read_scheduler #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1600000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        sync_tick,
    pulse_fifo_read_scheduler_if.master bus,
    output logic                        busy,
    output logic [15:0]                 missed_ticks,
    output logic [7:0]                  timeouts
);
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        OFFER   = 2'd3
    } state_t;

    state_t            state_r;
    logic              fifo_rd_en_r;
    logic              tft_valid_r;
    logic              uart_valid_r;
    logic              busy_r;
    logic [DATA_W-1:0] word_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic [15:0]       missed_r;
    logic [7:0]        timeouts_r;

    logic              tft_left_s;
    logic              uart_left_s;
    logic              tick_drop_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Pending handshakes after this edge, and ticks that will be dropped rather than served.
    always_comb begin
        tft_left_s  = tft_valid_r & ~bus.tft_ready;
        uart_left_s = uart_valid_r & ~bus.uart_ready;
        tick_drop_s = sync_tick & ((state_r != IDLE) | (en & bus.fifo_empty));
    end

    // Transaction FSM with all outputs and diagnostics counters registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            fifo_rd_en_r <= 1'b0;
            tft_valid_r  <= 1'b0;
            uart_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            word_r       <= '0;
            to_cnt_r     <= '0;
            missed_r     <= 16'd0;
            timeouts_r   <= 8'd0;
        end else begin
            if (tick_drop_s) begin
                missed_r <= sat_inc16(missed_r);
            end else begin
                missed_r <= missed_r;
            end
            case (state_r)
                IDLE: begin
                    if (sync_tick && en && !bus.fifo_empty) begin
                        state_r      <= READ;
                        fifo_rd_en_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                READ: begin
                    fifo_rd_en_r <= 1'b0;
                    state_r      <= CAPTURE;
                end
                CAPTURE: begin
                    word_r       <= bus.fifo_dout;
                    tft_valid_r  <= 1'b1;
                    uart_valid_r <= 1'b1;
                    to_cnt_r     <= '0;
                    state_r      <= OFFER;
                end
                OFFER: begin
                    // A handshake landing on the last allowed cycle still completes the transfer.
                    if (!tft_left_s && !uart_left_s) begin
                        tft_valid_r  <= 1'b0;
                        uart_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else if (to_cnt_r == TO_LAST) begin
                        tft_valid_r  <= 1'b0;
                        uart_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        timeouts_r   <= sat_inc8(timeouts_r);
                        state_r      <= IDLE;
                    end else begin
                        tft_valid_r  <= tft_left_s;
                        uart_valid_r <= uart_left_s;
                        to_cnt_r     <= to_cnt_r + TO_W'(1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    fifo_rd_en_r <= 1'b0;
                    tft_valid_r  <= 1'b0;
                    uart_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = fifo_rd_en_r;
    assign bus.word_out   = word_r;
    assign bus.tft_valid  = tft_valid_r;
    assign bus.uart_valid = uart_valid_r;
    assign busy           = busy_r;
    assign missed_ticks   = missed_r;
    assign timeouts       = timeouts_r;
endmodule
